// File: rtl/stream_arb_mux_pkg.sv
// Shared encodings for the stream arbiter/multiplexer: selection modes and packet-lock states.
package stream_arb_mux_pkg;

    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_e;

endpackage

// File: rtl/stream_arb_mux_rr_arbiter.sv
// Combinational round-robin arbiter: first requesting channel at or after ptr, wrapping modulo input_size.
module rr_arbiter #(
    parameter int input_size = 4,
    parameter int sel_len    = 2
) (
    input  logic [input_size-1:0] req,
    input  logic [sel_len-1:0]    ptr,
    output logic [sel_len-1:0]    grant,
    output logic                  any_req
);

    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        // Outer loop walks the search order, inner loop maps it onto a constant bit index.
        for (int i = 0; i < input_size; i++) begin
            for (int j = 0; j < input_size; j++) begin
                if (!any_req && (j == (int'(ptr) + i) % input_size) && req[j]) begin
                    grant   = sel_len'(j);
                    any_req = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/stream_arb_mux.sv
// Registered N-channel word multiplexer: external-select or round-robin arbitration with a per-packet grant
// lock. A word moves on channel g when in_valid[g] & in_ready[g]; out_data is consumed when out_valid & out_ready.
module stream_arb_mux
    import stream_arb_mux_pkg::*;
#(
    parameter int word_len   = 8,
    parameter int input_size = 4,
    parameter int sel_len    = 2,
    parameter int mode       = MODE_SEL
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [word_len*input_size-1:0] in_data,
    input  logic [input_size-1:0]          in_valid,
    input  logic [input_size-1:0]          in_last,
    output logic [input_size-1:0]          in_ready,
    input  logic [sel_len-1:0]             sel,
    output logic [word_len-1:0]            out_data,
    output logic                           out_valid,
    output logic                           out_last,
    output logic [sel_len-1:0]             out_ch,
    input  logic                           out_ready,
    output logic                           sel_err
);

    lock_state_e          state, state_next;
    logic [sel_len-1:0]   lock_ch, rr_ptr, rr_next, cand, arb_grant;
    logic                 arb_any, cand_valid, cand_last, cand_ok;
    logic                 load, transfer, sel_ok, sel_err_set;
    logic [word_len-1:0]  cand_data;

    rr_arbiter #(
        .input_size(input_size),
        .sel_len   (sel_len)
    ) u_arb (
        .req    (in_valid),
        .ptr    (rr_ptr),
        .grant  (arb_grant),
        .any_req(arb_any)
    );

    always_comb begin
        load   = ~out_valid | out_ready;
        sel_ok = int'(sel) < input_size;

        cand = sel;
        if (state == ST_LOCKED)
            cand = lock_ch;
        else if (mode == MODE_RR)
            cand = arb_grant;

        // An out-of-range sel matches no channel, so cand_valid stays low and nothing transfers.
        cand_valid = 1'b0;
        cand_last  = 1'b0;
        cand_data  = '0;
        for (int g = 0; g < input_size; g++) begin
            if (sel_len'(g) == cand) begin
                cand_valid = in_valid[g];
                cand_last  = in_last[g];
                cand_data  = in_data[(input_size-1-g)*word_len +: word_len];
            end
        end

        if (state == ST_UNLOCKED && mode == MODE_RR)
            cand_ok = arb_any;
        else
            cand_ok = cand_valid;

        transfer = load & cand_ok;

        in_ready = '0;
        for (int g = 0; g < input_size; g++)
            in_ready[g] = transfer & (sel_len'(g) == cand);

        rr_next = (cand == sel_len'(input_size - 1)) ? '0 : cand + sel_len'(1);

        sel_err_set = (mode == MODE_SEL) && (state == ST_UNLOCKED) && (|in_valid) && !sel_ok;

        state_next = state;
        if (transfer) begin
            if (state == ST_UNLOCKED && !cand_last)
                state_next = ST_LOCKED;
            else if (state == ST_LOCKED && cand_last)
                state_next = ST_UNLOCKED;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_UNLOCKED;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_ch    <= '0;
            sel_err   <= 1'b0;
            rr_ptr    <= '0;
            lock_ch   <= '0;
        end else begin
            if (transfer) begin
                out_valid <= 1'b1;
                out_data  <= cand_data;
                out_last  <= cand_last;
                out_ch    <= cand;
                if (state == ST_UNLOCKED)
                    lock_ch <= cand;
                if (mode == MODE_RR && cand_last)
                    rr_ptr <= rr_next;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (sel_err_set)
                sel_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_stream_arb_mux.sv
// Bench for stream_arb_mux: one external-select instance (sel_len=3) and one round-robin instance,
// each with its own expected-word queue drained by a negedge monitor.
module tb_stream_arb_mux;
    import stream_arb_mux_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // external-select instance
    logic [7:0]  s_word [4];
    logic [31:0] s_in_data;
    logic [3:0]  s_in_valid = '0, s_in_last = '0, s_in_ready;
    logic [2:0]  s_sel = '0, s_out_ch;
    logic [7:0]  s_out_data;
    logic        s_out_valid, s_out_last, s_sel_err;
    logic        s_out_ready = 1'b1;
    assign s_in_data = {s_word[0], s_word[1], s_word[2], s_word[3]};

    // round-robin instance
    logic [7:0]  r_word [4];
    logic [31:0] r_in_data;
    logic [3:0]  r_in_valid = '0, r_in_last = '0, r_in_ready;
    logic [1:0]  r_sel = '0, r_out_ch;
    logic [7:0]  r_out_data;
    logic        r_out_valid, r_out_last, r_sel_err;
    logic        r_out_ready = 1'b1;
    assign r_in_data = {r_word[0], r_word[1], r_word[2], r_word[3]};

    stream_arb_mux #(.word_len(8), .input_size(4), .sel_len(3), .mode(MODE_SEL)) dut_s (
        .clk(clk), .rst(rst), .in_data(s_in_data), .in_valid(s_in_valid), .in_last(s_in_last),
        .in_ready(s_in_ready), .sel(s_sel), .out_data(s_out_data), .out_valid(s_out_valid),
        .out_last(s_out_last), .out_ch(s_out_ch), .out_ready(s_out_ready), .sel_err(s_sel_err));

    stream_arb_mux #(.word_len(8), .input_size(4), .sel_len(2), .mode(MODE_RR)) dut_r (
        .clk(clk), .rst(rst), .in_data(r_in_data), .in_valid(r_in_valid), .in_last(r_in_last),
        .in_ready(r_in_ready), .sel(r_sel), .out_data(r_out_data), .out_valid(r_out_valid),
        .out_last(r_out_last), .out_ch(r_out_ch), .out_ready(r_out_ready), .sel_err(r_sel_err));

    int n_cmp = 0;
    int n_err = 0;
    logic [11:0] s_exp_q[$];
    logic [11:0] r_exp_q[$];

    // round-robin source table: per channel, words {last, data} and a read index
    logic [8:0] src_w [4][8];
    int         src_n [4];
    int         src_i [4];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] exp_word(input int ch, input logic last, input logic [7:0] d);
        return {3'(ch), last, d};
    endfunction

    always @(negedge clk) begin
        if (!rst && s_out_valid && s_out_ready) begin
            if (s_exp_q.size() == 0) check_eq("s_spurious_word", 0, 1);
            else check_eq("s_out_word", {s_out_ch, s_out_last, s_out_data}, s_exp_q.pop_front());
        end
        if (!rst && r_out_valid && r_out_ready) begin
            if (r_exp_q.size() == 0) check_eq("r_spurious_word", 0, 1);
            else check_eq("r_out_word", {1'b0, r_out_ch, r_out_last, r_out_data}, r_exp_q.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rr_clear();
        for (int ch = 0; ch < 4; ch++) begin
            src_n[ch] = 0;
            src_i[ch] = 0;
        end
    endtask

    task automatic rr_run(input int max_cycles, output int n_acc, output int span);
        int  first, lastc, cyc;
        bit  busy;
        first = -1; lastc = -1; n_acc = 0; cyc = 0; busy = 1'b1;
        while (busy && cyc < max_cycles) begin
            for (int ch = 0; ch < 4; ch++) begin
                r_in_valid[ch] = (src_i[ch] < src_n[ch]);
                if (src_i[ch] < src_n[ch]) {r_in_last[ch], r_word[ch]} = src_w[ch][src_i[ch]];
            end
            @(negedge clk);
            check_eq("r_ready_onehot", ($countones(r_in_ready) <= 1), 1);
            for (int ch = 0; ch < 4; ch++) begin
                if (r_in_valid[ch] && r_in_ready[ch]) begin
                    src_i[ch]++;
                    n_acc++;
                    if (first < 0) first = cyc;
                    lastc = cyc;
                end
            end
            step();
            cyc++;
            busy = 1'b0;
            for (int ch = 0; ch < 4; ch++) if (src_i[ch] < src_n[ch]) busy = 1'b1;
        end
        r_in_valid = '0;
        for (int ch = 0; ch < 4; ch++) check_eq("r_src_done", src_i[ch], src_n[ch]);
        span = lastc - first;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0] d0, d1, d2, w [5];
    int n_acc, span;

    initial begin
        for (int ch = 0; ch < 4; ch++) begin
            s_word[ch] = '0;
            r_word[ch] = '0;
        end
        rr_clear();

        // reset state
        #2;
        check_eq("rst_s_out_valid", s_out_valid, 0);
        check_eq("rst_s_out_data", s_out_data, 0);
        check_eq("rst_s_sel_err", s_sel_err, 0);
        check_eq("rst_r_out_valid", r_out_valid, 0);
        check_eq("rst_r_out_ch", r_out_ch, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // mode 0: sel=2, single word 0xA5 on ch2
        s_sel = 3'd2; s_word[2] = 8'hA5; s_in_last = 4'b0100; s_in_valid = 4'b0100;
        @(negedge clk);
        check_eq("s_sel2_ready", s_in_ready, 4'b0100);
        s_exp_q.push_back(exp_word(2, 1'b1, 8'hA5));
        step();
        s_in_valid = '0;
        @(negedge clk);
        check_eq("s_sel2_valid", s_out_valid, 1);
        check_eq("s_sel2_data", s_out_data, 8'hA5);
        check_eq("s_sel2_ch", s_out_ch, 2);
        check_eq("s_sel2_last", s_out_last, 1);
        step();

        // mode 0 lock: sel moves to ch3 mid-packet, ch1 keeps the grant
        d0 = 8'($urandom_range(0, 255)); d1 = 8'($urandom_range(0, 255)); d2 = 8'($urandom_range(0, 255));
        s_sel = 3'd1; s_word[1] = d0; s_word[3] = d2; s_in_last = 4'b1000; s_in_valid = 4'b1010;
        @(negedge clk);
        check_eq("s_lock_first_ready", s_in_ready, 4'b0010);
        s_exp_q.push_back(exp_word(1, 1'b0, d0));
        step();
        s_word[1] = d1; s_in_last = 4'b1010; s_sel = 3'd3;
        @(negedge clk);
        check_eq("s_locked_ready", s_in_ready, 4'b0010);
        s_exp_q.push_back(exp_word(1, 1'b1, d1));
        step();
        s_in_valid = 4'b1000;
        @(negedge clk);
        check_eq("s_unlocked_ready", s_in_ready, 4'b1000);
        s_exp_q.push_back(exp_word(3, 1'b1, d2));
        step();
        s_in_valid = '0;
        step();

        // backpressure: held word stable for 3 stalled cycles, then drain and refill together
        d0 = 8'($urandom_range(0, 255)); d1 = 8'($urandom_range(0, 255));
        s_out_ready = 1'b0; s_sel = 3'd0; s_word[0] = d0; s_in_last = 4'b0001; s_in_valid = 4'b0001;
        @(negedge clk);
        check_eq("s_bp_first_ready", s_in_ready, 4'b0001);
        s_exp_q.push_back(exp_word(0, 1'b1, d0));
        step();
        s_word[0] = d1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("s_bp_ready_low", s_in_ready, 0);
            check_eq("s_bp_valid_held", s_out_valid, 1);
            check_eq("s_bp_data_stable", s_out_data, d0);
            step();
        end
        s_out_ready = 1'b1;
        @(negedge clk);
        check_eq("s_bp_release_ready", s_in_ready, 4'b0001);
        s_exp_q.push_back(exp_word(0, 1'b1, d1));
        step();
        s_in_valid = '0;
        @(negedge clk);
        check_eq("s_bp_refill_data", s_out_data, d1);
        step();

        // out-of-range select: sticky error, no transfer
        s_sel = 3'd5; s_in_last = 4'hF; s_in_valid = 4'hF;
        @(negedge clk);
        check_eq("s_badsel_ready", s_in_ready, 0);
        check_eq("s_badsel_err_before", s_sel_err, 0);
        step();
        @(negedge clk);
        check_eq("s_badsel_err_set", s_sel_err, 1);
        check_eq("s_badsel_no_out", s_out_valid, 0);
        step();
        d0 = 8'($urandom_range(0, 255));
        s_sel = 3'd0; s_word[0] = d0; s_in_valid = 4'b0001;
        @(negedge clk);
        check_eq("s_goodsel_ready", s_in_ready, 4'b0001);
        s_exp_q.push_back(exp_word(0, 1'b1, d0));
        step();
        s_in_valid = '0;
        @(negedge clk);
        check_eq("s_err_sticky", s_sel_err, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("s_err_cleared", s_sel_err, 0);
        check_eq("s_rst_out_valid", s_out_valid, 0);
        s_exp_q.delete();
        step();
        rst = 1'b0;

        // mode 1: all channels valid with single-word packets -> 0,1,2,3,0 at one word per cycle
        rr_clear();
        for (int k = 0; k < 5; k++) w[k] = 8'($urandom_range(0, 255));
        src_w[0][0] = {1'b1, w[0]}; src_w[0][1] = {1'b1, w[4]}; src_n[0] = 2;
        for (int ch = 1; ch < 4; ch++) begin
            src_w[ch][0] = {1'b1, w[ch]};
            src_n[ch] = 1;
        end
        r_exp_q.push_back(exp_word(0, 1'b1, w[0]));
        r_exp_q.push_back(exp_word(1, 1'b1, w[1]));
        r_exp_q.push_back(exp_word(2, 1'b1, w[2]));
        r_exp_q.push_back(exp_word(3, 1'b1, w[3]));
        r_exp_q.push_back(exp_word(0, 1'b1, w[4]));
        rr_run(20, n_acc, span);
        check_eq("r_rr_accepts", n_acc, 5);
        check_eq("r_rr_throughput_span", span, 4);
        step();

        // mode 1: pointer now at ch1; ch1 3-word packet with ch0 and ch3 waiting -> 1,1,1,3,0
        rr_clear();
        for (int k = 0; k < 5; k++) w[k] = 8'($urandom_range(0, 255));
        src_w[1][0] = {1'b0, w[0]}; src_w[1][1] = {1'b0, w[1]}; src_w[1][2] = {1'b1, w[2]}; src_n[1] = 3;
        src_w[3][0] = {1'b1, w[3]}; src_n[3] = 1;
        src_w[0][0] = {1'b1, w[4]}; src_n[0] = 1;
        r_exp_q.push_back(exp_word(1, 1'b0, w[0]));
        r_exp_q.push_back(exp_word(1, 1'b0, w[1]));
        r_exp_q.push_back(exp_word(1, 1'b1, w[2]));
        r_exp_q.push_back(exp_word(3, 1'b1, w[3]));
        r_exp_q.push_back(exp_word(0, 1'b1, w[4]));
        rr_run(20, n_acc, span);
        check_eq("r_pkt_accepts", n_acc, 5);
        check_eq("r_pkt_throughput_span", span, 4);
        step();

        // reset while locked on ch2 with a word held under backpressure
        d0 = 8'($urandom_range(0, 255)); d1 = 8'($urandom_range(0, 255)); d2 = 8'($urandom_range(0, 255));
        r_word[2] = d0; r_in_last = 4'b0000; r_in_valid = 4'b0100;
        @(negedge clk);
        check_eq("r_lock2_ready", r_in_ready, 4'b0100);
        r_exp_q.push_back(exp_word(2, 1'b0, d0));
        step();
        r_out_ready = 1'b0; r_word[2] = d1; r_in_last = 4'b0101; r_word[0] = d2; r_in_valid = 4'b0101;
        @(negedge clk);
        check_eq("r_lock2_stall_ready", r_in_ready, 0);
        check_eq("r_lock2_held_ch", r_out_ch, 2);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("r_midrst_out_valid", r_out_valid, 0);
        check_eq("r_midrst_out_data", r_out_data, 0);
        check_eq("r_midrst_out_last", r_out_last, 0);
        check_eq("r_midrst_out_ch", r_out_ch, 0);
        r_exp_q.delete();
        step();
        rst = 1'b0; r_out_ready = 1'b1;
        @(negedge clk);
        check_eq("r_after_rst_ch0_wins", r_in_ready, 4'b0001);
        r_exp_q.push_back(exp_word(0, 1'b1, d2));
        step();
        r_in_valid = 4'b0100;
        @(negedge clk);
        check_eq("r_after_rst_ch2_ready", r_in_ready, 4'b0100);
        r_exp_q.push_back(exp_word(2, 1'b1, d1));
        step();
        r_in_valid = '0;

        repeat (4) step();
        check_eq("s_q_drained", s_exp_q.size(), 0);
        check_eq("r_q_drained", r_exp_q.size(), 0);
        check_eq("r_sel_err_unused", r_sel_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
